// File: rtl/time_set_ctrl_pkg.sv
// Shared definitions for the clock time-set controller: state/field codes,
// field limits and the per-counter control bundle.
package time_set_ctrl_pkg;

    // State codes double as the display field-select codes.
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2,
        SET_SEG = 2'd3
    } state_t;

    localparam logic [5:0] SEG_MAX = 6'd59;
    localparam logic [5:0] MIN_MAX = 6'd59;
    localparam logic [4:0] HR_MAX  = 5'd23;

    typedef struct packed {
        logic en;
        logic up;
        logic down;
    } ctl_t;

    localparam ctl_t CTL_IDLE = '{en: 1'b0, up: 1'b0, down: 1'b0};
    localparam ctl_t CTL_UP   = '{en: 1'b1, up: 1'b1, down: 1'b0};
    localparam ctl_t CTL_DOWN = '{en: 1'b1, up: 1'b0, down: 1'b1};

    function automatic state_t next_field(input state_t s);
        case (s)
            RUN:     return SET_HR;
            SET_HR:  return SET_MIN;
            SET_MIN: return SET_SEG;
            default: return RUN;
        endcase
    endfunction

endpackage

// File: rtl/time_set_ctrl_edge_pulse.sv
// Registered rising-edge detector: one single-cycle pulse per low-to-high
// transition of a debounced level, one cycle after the rise is sampled.
module edge_pulse (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic pulse
);

    logic prev;

    // NOTE: non-blocking assignments so prev and pulse both see the old level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev  <= 1'b0;
            pulse <= 1'b0;
        end else begin
            prev  <= level;
            pulse <= level & ~prev;
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// Time-set controller: turns the 1 Hz tick into carry-chained counter enables
// in RUN, and routes up/down buttons to the selected field in the SET states.
// Optional idle auto-return to RUN is built when SET_TIMEOUT_EN is defined.
module time_set_ctrl
    import time_set_ctrl_pkg::*;
#(
    parameter int unsigned BLINK_DIV   = 25000000,
    parameter int unsigned TIMEOUT_CYC = 500000000
) (
    input  logic       clkctl,
    input  logic       resetctl,
    input  logic       tick1hz,
    input  logic       btnmode,
    input  logic       btnup,
    input  logic       btndown,
    input  logic [5:0] qseg,
    input  logic [5:0] qmin,
    input  logic [4:0] qhr,
    output logic       enseg,
    output logic       upseg,
    output logic       downseg,
    output logic       enmin,
    output logic       upmin,
    output logic       downmin,
    output logic       enhr,
    output logic       uphr,
    output logic       downhr,
    output logic [1:0] fieldsel,
    output logic       blink
);

    localparam int unsigned BW = $clog2(BLINK_DIV + 1);

    state_t        state, state_nx;
    ctl_t          seg_nx, min_nx, hr_nx;
    logic          mode_evt, up_evt, down_evt;
    logic          btn_evt, step_up, step_dn, idle_hit;
    logic [BW-1:0] blink_cnt;
    logic          blink_q;

    edge_pulse u_mode (.clk(clkctl), .rst(resetctl), .level(btnmode), .pulse(mode_evt));
    edge_pulse u_up   (.clk(clkctl), .rst(resetctl), .level(btnup),   .pulse(up_evt));
    edge_pulse u_down (.clk(clkctl), .rst(resetctl), .level(btndown), .pulse(down_evt));

    assign btn_evt = mode_evt | up_evt | down_evt;
    assign step_up = up_evt & ~down_evt;
    assign step_dn = down_evt & ~up_evt;

`ifdef SET_TIMEOUT_EN
    localparam int unsigned IW = $clog2(TIMEOUT_CYC + 1);
    logic [IW-1:0] idle_cnt;

    always_ff @(posedge clkctl or posedge resetctl) begin
        if (resetctl)                     idle_cnt <= '0;
        else if (state == RUN || btn_evt) idle_cnt <= '0;
        else                              idle_cnt <= idle_cnt + 1'b1;
    end

    assign idle_hit = (state != RUN) && (idle_cnt == IW'(TIMEOUT_CYC - 1));
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC != 0);
    assign idle_hit       = 1'b0;
`endif

    // NOTE: every output of this block gets a default first, so no latches.
    always_comb begin
        state_nx = state;
        seg_nx   = CTL_IDLE;
        min_nx   = CTL_IDLE;
        hr_nx    = CTL_IDLE;
        if (state == RUN) begin
            if (tick1hz) begin
                seg_nx = CTL_UP;
                if (qseg == SEG_MAX) begin
                    min_nx = CTL_UP;
                    if (qmin == MIN_MAX) hr_nx = CTL_UP;
                end
            end
            if (mode_evt) state_nx = SET_HR;
        end else if (mode_evt) begin
            state_nx = next_field(state);
        end else if (idle_hit) begin
            state_nx = RUN;
        end else if (step_up) begin
            case (state)
                SET_HR:  hr_nx  = CTL_UP;
                SET_MIN: min_nx = CTL_UP;
                SET_SEG: seg_nx = CTL_UP;
                default: ;
            endcase
        end else if (step_dn) begin
            // Counters cannot load, so decrementing past zero is refused.
            case (state)
                SET_HR:  if (qhr  != '0) hr_nx  = CTL_DOWN;
                SET_MIN: if (qmin != '0) min_nx = CTL_DOWN;
                SET_SEG: if (qseg != '0) seg_nx = CTL_DOWN;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clkctl or posedge resetctl) begin
        if (resetctl) begin
            state                     <= RUN;
            {enseg, upseg, downseg}   <= '0;
            {enmin, upmin, downmin}   <= '0;
            {enhr, uphr, downhr}      <= '0;
            blink_cnt                 <= '0;
            blink_q                   <= 1'b0;
        end else begin
            state                     <= state_nx;
            {enseg, upseg, downseg}   <= seg_nx;
            {enmin, upmin, downmin}   <= min_nx;
            {enhr, uphr, downhr}      <= hr_nx;
            // Any button activity restarts the visible half-period.
            if (state_nx == RUN || btn_evt) begin
                blink_cnt <= '0;
                blink_q   <= 1'b0;
            end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
                blink_cnt <= '0;
                blink_q   <= ~blink_q;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    assign fieldsel = state;
    assign blink    = blink_q;

endmodule
